// File: rtl/vx_commit_merge_pkg.sv
// Shared commit-path types and widths for the per-issue-slot result merger.
// Optional performance counters are enabled by defining COMMIT_PERF_EN.
package VX_gpu_pkg;

  localparam int unsigned THREAD_CNT    = 4;
  localparam int unsigned NUM_THREADS   = THREAD_CNT;
  localparam int unsigned WARP_CNT      = 4;
  localparam int unsigned NUM_WARPS     = WARP_CNT;
  localparam int unsigned ISSUE_CNT     = 1;
  localparam int unsigned ISSUE_WIDTH   = ISSUE_CNT;
  localparam int unsigned ISSUE_WIS_W   = ((WARP_CNT / ISSUE_CNT) > 1) ? $clog2(WARP_CNT / ISSUE_CNT) : 1;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned NR_BITS       = 5;
  localparam int unsigned UUID_W        = 8;
  localparam int unsigned PID_BITS      = 1;
  localparam int unsigned NUM_UNITS     = 4;
  localparam int unsigned UNIT_IDX_W    = 2;
  localparam int unsigned PERF_CTR_BITS = 8;
  localparam int unsigned TCNT_W        = $clog2(THREAD_CNT + 1);

  localparam int unsigned COMMIT_DATAW = UUID_W + ISSUE_WIS_W + THREAD_CNT + XLEN + 1 + NR_BITS
                                       + THREAD_CNT * XLEN + PID_BITS + 1 + 1;

  localparam logic [UNIT_IDX_W-1:0] COMMIT_ALU = 2'd0;
  localparam logic [UNIT_IDX_W-1:0] COMMIT_LSU = 2'd1;
  localparam logic [UNIT_IDX_W-1:0] COMMIT_FPU = 2'd2;
  localparam logic [UNIT_IDX_W-1:0] COMMIT_SFU = 2'd3;

  typedef struct packed {
    logic [UUID_W-1:0]                uuid;
    logic [ISSUE_WIS_W-1:0]           wis;
    logic [THREAD_CNT-1:0]            tmask;
    logic [XLEN-1:0]                  pc;
    logic                             wb;
    logic [NR_BITS-1:0]               rd;
    logic [THREAD_CNT-1:0][XLEN-1:0]  data;
    logic [PID_BITS-1:0]              pid;
    logic                             sop;
    logic                             eop;
  } commit_data_t;

  function automatic logic [TCNT_W-1:0] popcount(input logic [THREAD_CNT-1:0] mask);
    logic [TCNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(THREAD_CNT); i++) begin
      cnt = cnt + TCNT_W'(mask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vx_commit_merge_rr_arb.sv
// Combinational round-robin grant with packet lock; pointer and lock state are held by the caller.
module VX_commit_rr_arb
  import VX_gpu_pkg::*;
(
  input  logic [NUM_UNITS-1:0]  i_req,
  input  logic                  i_lock,
  input  logic [UNIT_IDX_W-1:0] i_lock_id,
  input  logic [UNIT_IDX_W-1:0] i_prio,
  output logic [NUM_UNITS-1:0]  o_grant,
  output logic [UNIT_IDX_W-1:0] o_grant_idx,
  output logic                  o_grant_vld
);

  logic [UNIT_IDX_W-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    w_idx       = '0;
    if (i_lock) begin
      o_grant_idx        = i_lock_id;
      o_grant_vld        = i_req[i_lock_id];
      o_grant[i_lock_id] = i_req[i_lock_id];
    end else begin
      // scan upward from the priority pointer; the 2-bit index wraps naturally
      for (int k = 0; k < int'(NUM_UNITS); k++) begin
        w_idx = i_prio + UNIT_IDX_W'(k);
        if (!o_grant_vld && i_req[w_idx]) begin
          o_grant_vld    = 1'b1;
          o_grant_idx    = w_idx;
          o_grant[w_idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vx_commit_merge.sv
// Merges ALU/LSU/FPU/SFU result streams of one issue slot into a 2-deep buffered commit stream.
// Define COMMIT_PERF_EN to add the perf_instrs / perf_threads counters.
module vx_commit_merge
  import VX_gpu_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_UNITS-1:0]                   unit_valid,
  input  logic [NUM_UNITS-1:0][COMMIT_DATAW-1:0] unit_data,
  output logic [NUM_UNITS-1:0]                   unit_ready,
  output logic                                   commit_valid,
  output logic [COMMIT_DATAW-1:0]                commit_data,
  input  logic                                   commit_ready,
  output logic                                   busy
`ifdef COMMIT_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]               perf_instrs,
  output logic [PERF_CTR_BITS-1:0]               perf_threads
`endif
);

  logic                  r_locked;
  logic [UNIT_IDX_W-1:0] r_lock_id;
  logic [UNIT_IDX_W-1:0] r_prio;

  commit_data_t          r_mem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic                  r_full;
  logic                  r_empty;

  logic [NUM_UNITS-1:0]  w_grant;
  logic [UNIT_IDX_W-1:0] w_grant_idx;
  logic                  w_grant_vld;
  commit_data_t          w_in_data;
  commit_data_t          w_out_data;
  logic                  w_push;
  logic                  w_pop;

  VX_commit_rr_arb u_arb (
    .i_req       (unit_valid),
    .i_lock      (r_locked),
    .i_lock_id   (r_lock_id),
    .i_prio      (r_prio),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_vld (w_grant_vld)
  );

  // full is registered so ready never looks at commit_ready
  assign unit_ready = (reset || r_full) ? '0 : w_grant;
  assign w_in_data  = commit_data_t'(unit_data[w_grant_idx]);
  assign w_push     = w_grant_vld && |(unit_valid & unit_ready);
  assign w_pop      = !r_empty && commit_ready;
  assign w_out_data = r_mem[r_rptr];

  assign commit_valid = !r_empty;
  assign commit_data  = COMMIT_DATAW'(w_out_data);
  assign busy         = r_locked || !r_empty;

  // keep multi-packet results contiguous; advance pointer past the winner on eop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_locked  <= 1'b0;
      r_lock_id <= '0;
      r_prio    <= '0;
    end else if (w_push) begin
      if (w_in_data.eop) begin
        r_locked <= 1'b0;
        r_prio   <= w_grant_idx + UNIT_IDX_W'(1);
      end else begin
        r_locked  <= 1'b1;
        r_lock_id <= w_grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10: begin
          r_empty <= 1'b0;
          r_full  <= (~r_wptr == r_rptr);
        end
        2'b01: begin
          r_full  <= 1'b0;
          r_empty <= (~r_rptr == r_wptr);
        end
        default: ;
      endcase
    end
  end

`ifdef COMMIT_PERF_EN
  logic [PERF_CTR_BITS-1:0] r_perf_instrs;
  logic [PERF_CTR_BITS-1:0] r_perf_threads;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_instrs  <= '0;
      r_perf_threads <= '0;
    end else if (w_pop && w_out_data.eop) begin
      r_perf_instrs  <= r_perf_instrs + PERF_CTR_BITS'(1);
      r_perf_threads <= r_perf_threads + PERF_CTR_BITS'(popcount(w_out_data.tmask));
    end
  end

  assign perf_instrs  = r_perf_instrs;
  assign perf_threads = r_perf_threads;
`endif

endmodule

// File: tb/tb_vx_commit_merge.sv
// Directed self-checking bench for vx_commit_merge (perf checks only with COMMIT_PERF_EN).
module tb_vx_commit_merge;
  import VX_gpu_pkg::*;

  logic                                   clk;
  logic                                   reset;
  logic [NUM_UNITS-1:0]                   unit_valid;
  logic [NUM_UNITS-1:0][COMMIT_DATAW-1:0] unit_data;
  logic [NUM_UNITS-1:0]                   unit_ready;
  logic                                   commit_valid;
  logic [COMMIT_DATAW-1:0]                commit_data;
  logic                                   commit_ready;
  logic                                   busy;
`ifdef COMMIT_PERF_EN
  logic [PERF_CTR_BITS-1:0]               perf_instrs;
  logic [PERF_CTR_BITS-1:0]               perf_threads;
`endif

  int n_cmp = 0;
  int n_err = 0;

  vx_commit_merge dut (
    .clk          (clk),
    .reset        (reset),
    .unit_valid   (unit_valid),
    .unit_data    (unit_data),
    .unit_ready   (unit_ready),
    .commit_valid (commit_valid),
    .commit_data  (commit_data),
    .commit_ready (commit_ready),
    .busy         (busy)
`ifdef COMMIT_PERF_EN
    ,
    .perf_instrs  (perf_instrs),
    .perf_threads (perf_threads)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic commit_data_t mk(input logic [1:0] unit, input logic [7:0] id,
                                      input logic [3:0] tmask, input logic pid, input logic eop);
    commit_data_t d;
    d.uuid  = id;
    d.wis   = unit;
    d.tmask = tmask;
    d.pc    = 32'h1000 + 32'(id);
    d.wb    = 1'b1;
    d.rd    = id[4:0];
    d.data  = {4{32'hA000_0000 | 32'(id)}};
    d.pid   = pid;
    d.sop   = !pid;
    d.eop   = eop;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    unit_valid = '0;
    unit_data  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  commit_data_t d [4];
  int           rdy_cnt [4];
  int           acc;

  initial begin
    reset        = 1'b1;
    commit_ready = 1'b1;
    unit_valid   = '1;
    unit_data    = '0;
    tick();
    check_eq("rst_ready", 256'(unit_ready), 256'(0));
    check_eq("rst_valid", 256'(commit_valid), 256'(0));
    check_eq("rst_busy", 256'(busy), 256'(0));
`ifdef COMMIT_PERF_EN
    check_eq("rst_perf_instrs", 256'(perf_instrs), 256'(0));
`endif

    // single source, three single-packet results
    do_reset();
    for (int i = 0; i < 3; i++) d[i] = mk(COMMIT_ALU, 8'(8'h20 + i), 4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      unit_valid   = 4'b0001;
      unit_data[0] = d[i];
      @(negedge clk);
      check_eq("single_ready", 256'(unit_ready), 256'(4'b0001));
      tick();
      check_eq("single_valid", 256'(commit_valid), 256'(1));
      check_eq("single_data", 256'(commit_data), 256'(d[i]));
    end
    unit_valid = '0;
    tick();
    check_eq("single_drain", 256'(commit_valid), 256'(0));
`ifdef COMMIT_PERF_EN
    check_eq("single_perf_instrs", 256'(perf_instrs), 256'(3));
`endif

    // round-robin across all four units
    do_reset();
    for (int u = 0; u < 4; u++) begin
      unit_data[u] = mk(2'(u), 8'(8'h40 + u), 4'h1, 1'b0, 1'b1);
      rdy_cnt[u]   = 0;
    end
    unit_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("rr_grant", 256'(unit_ready), 256'(4'b0001 << (k % 4)));
      for (int u = 0; u < 4; u++) rdy_cnt[u] += int'(unit_ready[u]);
      tick();
      check_eq("rr_data", 256'(commit_data), 256'(mk(2'(k % 4), 8'(8'h40 + (k % 4)), 4'h1, 1'b0, 1'b1)));
    end
    for (int u = 0; u < 4; u++) check_eq("rr_count", 256'(rdy_cnt[u]), 256'(2));
    unit_valid = '0;
    tick();

    // lock: LSU two-packet result keeps ALU stalled
    do_reset();
    d[0] = mk(COMMIT_ALU, 8'h60, 4'h3, 1'b0, 1'b1);
    d[1] = mk(COMMIT_LSU, 8'h61, 4'h3, 1'b0, 1'b0);
    d[2] = mk(COMMIT_LSU, 8'h62, 4'h3, 1'b1, 1'b1);
    d[3] = mk(COMMIT_ALU, 8'h63, 4'h3, 1'b0, 1'b1);
    unit_valid   = 4'b0001;
    unit_data[0] = d[0];
    @(negedge clk);
    check_eq("lock_prep_ready", 256'(unit_ready), 256'(4'b0001));
    tick();
    unit_valid   = 4'b0011;
    unit_data[0] = d[3];
    unit_data[1] = d[1];
    @(negedge clk);
    check_eq("lock_lsu0_ready", 256'(unit_ready), 256'(4'b0010));
    tick();
    check_eq("lock_busy", 256'(busy), 256'(1));
    unit_data[1] = d[2];
    @(negedge clk);
    check_eq("lock_lsu1_ready", 256'(unit_ready), 256'(4'b0010));
    tick();
    check_eq("lock_out_lsu1", 256'(commit_data), 256'(d[2]));
    unit_valid = 4'b0001;
    @(negedge clk);
    check_eq("lock_alu_ready", 256'(unit_ready), 256'(4'b0001));
    tick();
    check_eq("lock_out_alu", 256'(commit_data), 256'(d[3]));
    unit_valid = '0;
    tick();

    // backpressure: buffer fills at two, then drains in order
    do_reset();
    commit_ready = 1'b0;
    for (int i = 0; i < 3; i++) d[i] = mk(COMMIT_FPU, 8'(8'h80 + i), 4'h5, 1'b0, 1'b1);
    unit_valid   = 4'b0100;
    unit_data[2] = d[0];
    @(negedge clk);
    check_eq("bp_ready0", 256'(unit_ready), 256'(4'b0100));
    tick();
    unit_data[2] = d[1];
    @(negedge clk);
    check_eq("bp_ready1", 256'(unit_ready), 256'(4'b0100));
    tick();
    unit_data[2] = d[2];
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("bp_full_ready", 256'(unit_ready), 256'(0));
      check_eq("bp_hold_data", 256'(commit_data), 256'(d[0]));
      tick();
    end
    commit_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_recover_ready", 256'(unit_ready), 256'(0));
    tick();
    check_eq("bp_out1", 256'(commit_data), 256'(d[1]));
    @(negedge clk);
    check_eq("bp_ready2", 256'(unit_ready), 256'(4'b0100));
    tick();
    check_eq("bp_out2", 256'(commit_data), 256'(d[2]));
    unit_valid = '0;
    tick();
    check_eq("bp_empty", 256'(commit_valid), 256'(0));

    // reset while an SFU result is mid-transfer
    do_reset();
    unit_valid   = 4'b1000;
    unit_data[3] = mk(COMMIT_SFU, 8'hA0, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("ml_sfu_ready", 256'(unit_ready), 256'(4'b1000));
    tick();
    check_eq("ml_busy_locked", 256'(busy), 256'(1));
    reset      = 1'b1;
    unit_valid = '0;
    #1;
    check_eq("ml_busy_reset", 256'(busy), 256'(0));
    check_eq("ml_valid_reset", 256'(commit_valid), 256'(0));
    for (int u = 0; u < 4; u++) unit_data[u] = mk(2'(u), 8'(8'hB0 + u), 4'h1, 1'b0, 1'b1);
    unit_valid = 4'b1111;
    #1;
    check_eq("ml_ready_in_reset", 256'(unit_ready), 256'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("ml_alu_first", 256'(unit_ready), 256'(4'b0001));
    tick();
    unit_valid = '0;
    tick();

`ifdef COMMIT_PERF_EN
    // perf counters: popcount accumulation, then wrap
    do_reset();
    unit_valid   = 4'b0001;
    unit_data[0] = mk(COMMIT_ALU, 8'hC0, 4'b1011, 1'b0, 1'b1);
    tick();
    unit_data[0] = mk(COMMIT_ALU, 8'hC1, 4'b0001, 1'b0, 1'b1);
    tick();
    unit_valid = '0;
    tick();
    check_eq("perf_threads", 256'(perf_threads), 256'(4));
    check_eq("perf_instrs", 256'(perf_instrs), 256'(2));
    acc          = 0;
    unit_valid   = 4'b0001;
    unit_data[0] = mk(COMMIT_ALU, 8'hC2, 4'b0001, 1'b0, 1'b1);
    for (int c = 0; c < 600 && acc < 255; c++) begin
      @(negedge clk);
      if (unit_valid[0] && unit_ready[0]) acc++;
      tick();
    end
    unit_valid = '0;
    check_eq("perf_wrap_accepts", 256'(acc), 256'(255));
    tick();
    tick();
    check_eq("perf_wrap_instrs", 256'(perf_instrs), 256'(8'd1));
    check_eq("perf_wrap_threads", 256'(perf_threads), 256'(8'd3));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
